// File: rtl/mat_pkg.sv
// Shared constants and types for the matrix-generation path: angle width,
// requester count and the requester IDs carried as tags.
package mat_pkg;

    localparam int ANG_W   = 32;
    localparam int REQ_NUM = 3;

    localparam int REQ_S12 = 0;
    localparam int REQ_A0  = 1;
    localparam int REQ_A1  = 2;

    typedef logic [1:0] tag_t;

endpackage

// File: rtl/cordic_share_sched_tag_fifo.sv
// Synchronous tag FIFO recording the requester ID of every operation issued
// to the shared CORDIC core; count doubles as the in-flight counter.
module tag_fifo #(
    parameter int W     = $bits(mat_pkg::tag_t),
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; validity is entirely governed by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cordic_share_sched.sv
// Shares one CORDIC core between the s12/a0/a1 angle requesters and returns
// tagged results in issue order. CORDIC_SHARE_FIXED_PRIO_EN selects fixed priority.
module cordic_share_sched #(
    parameter int ANG_W     = mat_pkg::ANG_W,
    parameter int REQ_NUM   = mat_pkg::REQ_NUM,
    parameter int TAG_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [REQ_NUM-1:0]            req_vld,
    input  logic [REQ_NUM*ANG_W-1:0]      req_theta,
    output logic [REQ_NUM-1:0]            req_rdy,
    output logic                          cor_in_vld,
    output logic [ANG_W-1:0]              cor_theta,
    input  logic                          cor_out_vld,
    input  logic [ANG_W-1:0]              cor_i,
    input  logic [ANG_W-1:0]              cor_r,
    output logic                          cor_out_rdy,
    output logic                          res_vld,
    output logic [$clog2(REQ_NUM)-1:0]    res_tag,
    output logic [ANG_W-1:0]              res_i,
    output logic [ANG_W-1:0]              res_r,
    input  logic                          res_rdy,
    output logic [$clog2(TAG_DEPTH):0]    inflight,
    output logic [CNT_W-1:0]              done_cnt,
    output logic                          idle,
    output logic                          err_orphan
);

    import mat_pkg::*;

    localparam int TAG_W = $bits(tag_t);

    logic [ANG_W-1:0]  theta_arr [REQ_NUM];
    logic [REQ_NUM-1:0] gnt;
    tag_t              win_id;
    logic [ANG_W-1:0]  win_theta;
    logic              can_issue;
    logic              found;
    tag_t              idx;
    logic [TAG_W:0]    idx_sum;
    tag_t              fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;

    for (genvar k = 0; k < REQ_NUM; k++) begin : g_theta
        assign theta_arr[k] = req_theta[k*ANG_W +: ANG_W];
    end

    // fifo_full reflects pre-pop occupancy, so a same-cycle pop never frees a slot.
    assign can_issue = en & ~fifo_full & (|req_vld);

`ifndef CORDIC_SHARE_FIXED_PRIO_EN
    tag_t rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= tag_t'(REQ_S12);
        else if (|gnt)
            rr_ptr <= (win_id == tag_t'(REQ_NUM-1)) ? '0 : win_id + 1'b1;
    end
`endif

    always_comb begin
        gnt       = '0;
        win_id    = '0;
        win_theta = '0;
        found     = 1'b0;
        idx       = '0;
        idx_sum   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
`ifdef CORDIC_SHARE_FIXED_PRIO_EN
            idx_sum = (TAG_W+1)'(i);
`else
            idx_sum = {1'b0, rr_ptr} + (TAG_W+1)'(i);
            if (idx_sum >= (TAG_W+1)'(REQ_NUM))
                idx_sum = idx_sum - (TAG_W+1)'(REQ_NUM);
`endif
            idx = idx_sum[TAG_W-1:0];
            if (can_issue && !found && req_vld[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                win_id    = idx;
                win_theta = theta_arr[idx];
            end
        end
    end

    // Issue stage: one-cycle pulse to the core per grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cor_in_vld <= 1'b0;
            cor_theta  <= '0;
            done_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            cor_in_vld <= |gnt;
            if (|gnt)
                cor_theta <= win_theta;
            if (pop)
                done_cnt <= done_cnt + 1'b1;
            if (cor_out_vld && fifo_empty)
                err_orphan <= 1'b1;
        end
    end

    tag_fifo #(
        .W     (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (|gnt),
        .din   (win_id),
        .pop   (pop),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (inflight)
    );

    // Return stage: results pass straight through, tagged with the FIFO head.
    assign pop         = cor_out_vld & res_rdy & ~fifo_empty;
    assign req_rdy     = gnt;
    assign res_vld     = cor_out_vld & ~fifo_empty;
    assign res_tag     = fifo_head;
    assign res_i       = cor_i;
    assign res_r       = cor_r;
    assign cor_out_rdy = res_rdy;
    assign idle        = (inflight == '0) & ~cor_in_vld;

endmodule
